// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e        : converter FSM states
//   BCD_DIGIT_W    : bits per BCD digit
//   ADJ_THRESH     : digit value at or above which the add-3 correction applies
//   ADJ_VALUE      : correction added to a digit before each shift
//   digits_fit()   : true when DIGITS decimal digits can hold any WIDTH-bit value
package bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADJ_THRESH  = 5;
  localparam int ADJ_VALUE   = 3;

  // 10**digits >= 2**width, saturating the power of ten so large DIGITS
  // values cannot wrap the intermediate product.
  function automatic bit digits_fit(input int width, input int digits);
    longint lim;
    longint cap;
    lim = longint'(1) << width;
    cap = 1;
    for (int i = 0; i < digits; i++) begin
      if (cap < lim) begin
        cap = cap * 10;
      end
    end
    return (cap >= lim);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
//   digit_in  : current BCD scratch digit
//   digit_out : corrected digit (4-bit wrap, no carry out)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  assign digit_out = (digit_in >= BCD_DIGIT_W'(ADJ_THRESH))
                     ? digit_in + BCD_DIGIT_W'(ADJ_VALUE)
                     : digit_in;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter, shift-and-add-3, one input bit per clock.
// A conversion takes WIDTH cycles from the accepting edge to the done pulse.
//
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : conversion request, sampled only while idle
//   bin_in   : binary value, captured on the accepting edge
//   busy     : high while converting
//   done     : one-cycle pulse when bcd_out/ovf are updated
//   bcd_out  : BCD result, digit 0 (units) in bits [3:0]
//   ovf      : result did not fit in DIGITS digits
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; bcd_out/ovf hold the last result
// CONV  | adjust digits, shift one bit per clock; counter counts down
//
// STRICT_DIGITS=1 rejects a DIGITS value too small for WIDTH at elaboration.
// Clearing it allows a deliberately narrow display, with ovf reporting the
// values that lost their top digit.
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DIGITS        = 3,
  parameter bit STRICT_DIGITS = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          ovf
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("binary_to_bcd_seq: WIDTH must be in 2..16");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("binary_to_bcd_seq: DIGITS must be at least 1");
  end
  if (STRICT_DIGITS && !digits_fit(WIDTH, DIGITS)) begin : g_digits_too_few
    $error("binary_to_bcd_seq: DIGITS too small to hold 2**WIDTH-1");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_shift_q, bin_shift_d;
  logic [BCD_W-1:0]   bcd_scr_q, bcd_scr_d;
  logic               ovf_scr_q, ovf_scr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (bcd_scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_d     = state_q;
    bin_shift_d = bin_shift_q;
    bcd_scr_d   = bcd_scr_q;
    ovf_scr_d   = ovf_scr_q;
    cnt_d       = cnt_q;
    bcd_out_d   = bcd_out_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          bin_shift_d = bin_in;
          bcd_scr_d   = '0;
          ovf_scr_d   = 1'b0;
          cnt_d       = CNT_W'(WIDTH);
          state_d     = CONV;
        end
      end

      CONV: begin
        // Adjusted digits and the binary register shift left as one vector;
        // whatever leaves the top digit is lost and flags overflow.
        bin_shift_d = {bin_shift_q[WIDTH-2:0], 1'b0};
        bcd_scr_d   = {bcd_adj[BCD_W-2:0], bin_shift_q[WIDTH-1]};
        ovf_scr_d   = ovf_scr_q | bcd_adj[BCD_W-1];
        cnt_d       = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_out_d = bcd_scr_d;
          ovf_d     = ovf_scr_d;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_shift_q <= '0;
      bcd_scr_q   <= '0;
      ovf_scr_q   <= 1'b0;
      cnt_q       <= '0;
      bcd_out_q   <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_shift_q <= bin_shift_d;
      bcd_scr_q   <= bcd_scr_d;
      ovf_scr_q   <= ovf_scr_d;
      cnt_q       <= cnt_d;
      bcd_out_q   <= bcd_out_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign busy    = (state_q == CONV);
  assign done    = done_q;
  assign bcd_out = bcd_out_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq: a default 8-bit/3-digit instance and
// a narrow 8-bit/2-digit instance for the overflow cases.
module tb_binary_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic        ovf;

  logic        start2;
  logic [7:0]  bin_in2;
  logic        busy2;
  logic        done2;
  logic [7:0]  bcd_out2;
  logic        ovf2;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(2), .STRICT_DIGITS(1'b0)) u_dut_narrow (
    .clk     (clk),
    .rst     (rst),
    .start   (start2),
    .bin_in  (bin_in2),
    .busy    (busy2),
    .done    (done2),
    .bcd_out (bcd_out2),
    .ovf     (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #500us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one conversion and stop on the cycle where done is high
  // (or after a bounded number of cycles).
  task automatic run_conv(input logic [7:0] v, output logic [11:0] res,
                          output logic res_ovf, output int lat, output int busy_cyc);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    res     = bcd_out;
    res_ovf = ovf;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  logic [11:0] res;
  logic        res_ovf;
  logic [11:0] exp_bcd;
  int          lat;
  int          busy_cyc;
  int          d0;
  int          t1;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    bin_in  = 8'd0;
    start2  = 1'b0;
    bin_in2 = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd_out), 32'h000);
    check("rst_ovf",  32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero input: latency and busy duration
    run_conv(8'd0, res, res_ovf, lat, busy_cyc);
    check("zero_done",    32'(done), 32'd1);
    check("zero_latency", 32'(lat), 32'd8);
    check("zero_busy",    32'(busy_cyc), 32'd8);
    check("zero_bcd",     32'(res), 32'h000);
    check("zero_ovf",     32'(res_ovf), 32'd0);
    @(negedge clk);
    check("zero_done_1cyc", 32'(done), 32'd0);

    // Directed values
    run_conv(8'd255, res, res_ovf, lat, busy_cyc);
    check("v255_bcd", 32'(res), 32'h255);
    check("v255_ovf", 32'(res_ovf), 32'd0);
    @(negedge clk);
    run_conv(8'd99, res, res_ovf, lat, busy_cyc);
    check("v99_bcd", 32'(res), 32'h099);
    @(negedge clk);
    run_conv(8'd100, res, res_ovf, lat, busy_cyc);
    check("v100_bcd", 32'(res), 32'h100);
    @(negedge clk);

    // Full sweep against decimal division
    for (int v = 0; v < 256; v++) begin
      exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      run_conv(8'(v), res, res_ovf, lat, busy_cyc);
      check($sformatf("sweep_done_%0d", v), 32'(done), 32'd1);
      check($sformatf("sweep_bcd_%0d", v), 32'(res), 32'(exp_bcd));
      check($sformatf("sweep_ovf_%0d", v), 32'(res_ovf), 32'd0);
      @(negedge clk);
      check($sformatf("sweep_done_low_%0d", v), 32'(done), 32'd0);
    end

    // start during busy is ignored; bin_in changes during CONV are ignored
    start  = 1'b1;
    bin_in = 8'd42;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd7;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'hAA;
    wait_done(lat);
    check("busy_start_done", 32'(done), 32'd1);
    check("busy_start_bcd",  32'(bcd_out), 32'h042);
    repeat (14) @(negedge clk);
    check("busy_start_single_done", 32'(done_cnt - d0), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);

    // Back-to-back: start on the done cycle
    run_conv(8'd64, res, res_ovf, lat, busy_cyc);
    check("b2b_first_bcd", 32'(res), 32'h064);
    t1     = cyc;
    start  = 1'b1;
    bin_in = 8'd128;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_second_bcd",  32'(bcd_out), 32'h128);
    check("b2b_spacing",     32'(cyc - t1), 32'd9);
    @(negedge clk);

    // Reset mid-conversion: no done, outputs cleared
    start  = 1'b1;
    bin_in = 8'd200;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bcd",  32'(bcd_out), 32'h000);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    run_conv(8'd13, res, res_ovf, lat, busy_cyc);
    check("post_rst_bcd", 32'(res), 32'h013);
    @(negedge clk);

    // Narrow instance: 150 loses its hundreds digit
    start2  = 1'b1;
    bin_in2 = 8'd150;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("narrow150_done", 32'(done2), 32'd1);
    check("narrow150_ovf",  32'(ovf2), 32'd1);
    check("narrow150_bcd",  32'(bcd_out2), 32'h50);
    @(negedge clk);
    start2  = 1'b1;
    bin_in2 = 8'd99;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("narrow99_done", 32'(done2), 32'd1);
    check("narrow99_ovf",  32'(ovf2), 32'd0);
    check("narrow99_bcd",  32'(bcd_out2), 32'h99);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
